// File: rtl/ped_xing_ctrl.sv
// Multi-crosswalk pedestrian/vehicle signal controller on an external tick time base.
// Optional `PED_PREEMPT_EN adds a level preempt input that blocks GREEN exit and cuts WALK short.
module ped_xing_ctrl #(
    parameter int NUM_XWALK   = 2,
    parameter int TIMER_W     = 8,
    parameter int GREEN_MIN   = 20,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 1,
    parameter int WALK_TIME   = 10,
    parameter int CLEAR_TIME  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [NUM_XWALK-1:0] ped_req,
`ifdef PED_PREEMPT_EN
    input  logic                 preempt,
`endif
    output logic                 car_green,
    output logic                 car_yellow,
    output logic                 car_red,
    output logic [NUM_XWALK-1:0] walk,
    output logic [NUM_XWALK-1:0] dont_walk_flash,
    output logic [NUM_XWALK-1:0] req_pending,
    output logic [2:0]           phase
);

    localparam int TMAX = 1 << TIMER_W;

    if (NUM_XWALK < 1 || NUM_XWALK > 8) begin : g_bad_xwalk
        $error("ped_xing_ctrl: NUM_XWALK must be 1..8");
    end
    if (GREEN_MIN < 1 || GREEN_MIN >= TMAX || YELLOW_TIME < 1 || YELLOW_TIME >= TMAX ||
        ALLRED_TIME < 1 || ALLRED_TIME >= TMAX || WALK_TIME < 1 || WALK_TIME >= TMAX ||
        CLEAR_TIME < 1 || CLEAR_TIME >= TMAX) begin : g_bad_dur
        $error("ped_xing_ctrl: durations must be nonzero and fit in TIMER_W");
    end

    localparam logic [TIMER_W-1:0] T_GREEN  = TIMER_W'(GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] T_YELLOW = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] T_ALLRED = TIMER_W'(ALLRED_TIME - 1);
    localparam logic [TIMER_W-1:0] T_WALK   = TIMER_W'(WALK_TIME - 1);
    localparam logic [TIMER_W-1:0] T_CLEAR  = TIMER_W'(CLEAR_TIME - 1);

    typedef enum logic [2:0] {
        S_GREEN   = 3'd0,
        S_YELLOW  = 3'd1,
        S_ALLRED1 = 3'd2,
        S_WALK    = 3'd3,
        S_CLEAR   = 3'd4,
        S_ALLRED2 = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [NUM_XWALK-1:0] served_q, served_d;
    logic [NUM_XWALK-1:0] req_q, req_d;
    logic [NUM_XWALK-1:0] ped_prev_q;
    logic [NUM_XWALK-1:0] rise;
    logic                 flash_q, flash_d;
    logic                 car_green_q, car_yellow_q, car_red_q;
    logic [NUM_XWALK-1:0] walk_q, dwf_q;
    logic                 tz;
    logic                 blk;
    logic                 frc;

`ifdef PED_PREEMPT_EN
    logic pre_prev_q, pre_hit_q, pre_hit_d;

    assign blk       = preempt;
    assign frc       = pre_hit_q | (preempt & ~pre_prev_q);
    // A rise seen in WALK is remembered until the next tick ends the phase.
    assign pre_hit_d = frc & (state_d == S_WALK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_prev_q <= 1'b0;
            pre_hit_q  <= 1'b0;
        end else begin
            pre_prev_q <= preempt;
            pre_hit_q  <= pre_hit_d;
        end
    end
`else
    assign blk = 1'b0;
    assign frc = 1'b0;
`endif

    assign rise = ped_req & ~ped_prev_q;
    assign tz   = (timer_q == '0);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        served_d = served_q;
        req_d    = req_q;
        flash_d  = flash_q;
        if (tick && !tz) begin
            timer_d = timer_q - 1'b1;
        end
        case (state_q)
            S_GREEN: begin
                if (tick && tz && (req_q != '0) && !blk) begin
                    state_d = S_YELLOW;
                    timer_d = T_YELLOW;
                end
            end
            S_YELLOW: begin
                if (tick && tz) begin
                    state_d = S_ALLRED1;
                    timer_d = T_ALLRED;
                end
            end
            S_ALLRED1: begin
                if (tick && tz) begin
                    state_d  = S_WALK;
                    timer_d  = T_WALK;
                    served_d = req_q;
                    req_d    = '0;
                end
            end
            S_WALK: begin
                if (tick && (tz || frc)) begin
                    state_d = S_CLEAR;
                    timer_d = T_CLEAR;
                    flash_d = 1'b0;
                end
            end
            S_CLEAR: begin
                if (tick) begin
                    flash_d = ~flash_q;
                end
                if (tick && tz) begin
                    state_d = S_ALLRED2;
                    timer_d = T_ALLRED;
                end
            end
            S_ALLRED2: begin
                if (tick && tz) begin
                    state_d  = S_GREEN;
                    timer_d  = T_GREEN;
                    served_d = '0;
                end
            end
            default: begin
                state_d = S_ALLRED2;
                timer_d = T_ALLRED;
            end
        endcase
        // New presses override the serve-time clear.
        req_d = req_d | rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_GREEN;
            timer_q      <= T_GREEN;
            served_q     <= '0;
            req_q        <= '0;
            ped_prev_q   <= '0;
            flash_q      <= 1'b0;
            car_green_q  <= 1'b1;
            car_yellow_q <= 1'b0;
            car_red_q    <= 1'b0;
            walk_q       <= '0;
            dwf_q        <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            served_q     <= served_d;
            req_q        <= req_d;
            ped_prev_q   <= ped_req;
            flash_q      <= flash_d;
            car_green_q  <= (state_d == S_GREEN);
            car_yellow_q <= (state_d == S_YELLOW);
            car_red_q    <= (state_d != S_GREEN) && (state_d != S_YELLOW);
            walk_q       <= served_d & {NUM_XWALK{state_d == S_WALK}};
            dwf_q        <= served_d & {NUM_XWALK{(state_d == S_CLEAR) && flash_d}};
        end
    end

    assign car_green       = car_green_q;
    assign car_yellow      = car_yellow_q;
    assign car_red         = car_red_q;
    assign walk            = walk_q;
    assign dont_walk_flash = dwf_q;
    assign req_pending     = req_q;
    assign phase           = state_q;

endmodule

// File: tb/tb_ped_xing_ctrl.sv
// Self-checking bench for ped_xing_ctrl with a per-cycle expected-value scoreboard.
// Default parameters; the preempt scenario builds only with PED_PREEMPT_EN.
module tb_ped_xing_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [1:0] ped_req;
`ifdef PED_PREEMPT_EN
    logic       preempt;
`endif
    logic       car_green, car_yellow, car_red;
    logic [1:0] walk, dont_walk_flash, req_pending;
    logic [2:0] phase;

    int n_chk = 0;
    int n_err = 0;
    logic [11:0] sb[$];

    ped_xing_ctrl dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .ped_req(ped_req),
`ifdef PED_PREEMPT_EN
        .preempt(preempt),
`endif
        .car_green(car_green),
        .car_yellow(car_yellow),
        .car_red(car_red),
        .walk(walk),
        .dont_walk_flash(dont_walk_flash),
        .req_pending(req_pending),
        .phase(phase)
    );

    always #5 clk = ~clk;

    // Expected output vector: {phase, green, yellow, red, walk, flash, pending}
    function automatic logic [11:0] mk(logic [2:0] ph, logic [1:0] w,
                                       logic [1:0] f, logic [1:0] r);
        logic g, y;
        g = (ph == 3'd0);
        y = (ph == 3'd1);
        return {ph, g, y, ~(g | y), w, f, r};
    endfunction

    // Reference timeline with tick=1: d = cycles since GREEN entry.
    function automatic logic [11:0] tl(int d, logic [1:0] srv, logic [1:0] r);
        logic [2:0] ph;
        logic [1:0] w, f;
        if (d < 20)       ph = 3'd0;
        else if (d < 23)  ph = 3'd1;
        else if (d == 23) ph = 3'd2;
        else if (d < 34)  ph = 3'd3;
        else if (d < 40)  ph = 3'd4;
        else if (d == 40) ph = 3'd5;
        else              ph = 3'd0;
        w = (ph == 3'd3) ? srv : 2'b00;
        f = (ph == 3'd4 && ((d - 34) % 2) == 1) ? srv : 2'b00;
        return mk(ph, w, f, r);
    endfunction

    function automatic logic [11:0] obs();
        return {phase, car_green, car_yellow, car_red, walk, dont_walk_flash, req_pending};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick = 1'b1;
        ped_req = 2'b00;
`ifdef PED_PREEMPT_EN
        preempt = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] e, o;
        rst = 1'b1;
        tick = 1'b1;
        ped_req = 2'b11;
`ifdef PED_PREEMPT_EN
        preempt = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        e = mk(3'd0, 2'b00, 2'b00, 2'b00);
        o = obs();
        n_chk++;
        if (o !== e) begin
            n_err++;
            $display("FAIL reset_held got %h exp %h", o, e);
        end
        ped_req = 2'b00;
        rst = 1'b0;
        #1;
        o = obs();
        n_chk++;
        if (o !== e) begin
            n_err++;
            $display("FAIL reset_release got %h exp %h", o, e);
        end
    endtask

    task automatic test_idle();
        logic [11:0] e, o;
        do_reset();
        for (int s = 1; s <= 104; s++) begin
            ped_req = (s == 101) ? 2'b01 : 2'b00;
            sb.push_back(mk((s >= 102) ? 3'd1 : 3'd0, 2'b00, 2'b00,
                            (s >= 101) ? 2'b01 : 2'b00));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = obs();
            n_chk++;
            if (o !== e) begin
                n_err++;
                $display("FAIL idle s=%0d got %h exp %h", s, o, e);
            end
        end
    endtask

    task automatic test_single_walk();
        logic [11:0] e, o;
        logic [1:0] er, pv;
        do_reset();
        er = 2'b00;
        pv = 2'b00;
        for (int s = 1; s <= 45; s++) begin
            ped_req = (s == 6) ? 2'b01 : 2'b00;
            if (s == 24) er = 2'b00;
            er |= ped_req & ~pv;
            pv = ped_req;
            sb.push_back(tl(s, 2'b01, er));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = obs();
            n_chk++;
            if (o !== e) begin
                n_err++;
                $display("FAIL single s=%0d got %h exp %h", s, o, e);
            end
        end
    endtask

    task automatic test_multi_walk();
        logic [11:0] e, o;
        logic [1:0] er, pv;
        do_reset();
        er = 2'b00;
        pv = 2'b00;
        for (int s = 1; s <= 45; s++) begin
            ped_req = {s >= 10, s == 3};
            if (s == 24) er = 2'b00;
            er |= ped_req & ~pv;
            pv = ped_req;
            sb.push_back(tl(s, 2'b11, er));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = obs();
            n_chk++;
            if (o !== e) begin
                n_err++;
                $display("FAIL multi s=%0d got %h exp %h", s, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e, o;
        logic [1:0] er, pv;
        do_reset();
        er = 2'b00;
        pv = 2'b00;
        for (int s = 1; s <= 76; s++) begin
            ped_req = {s == 27, s == 2};
            if (s == 24 || s == 65) er = 2'b00;
            er |= ped_req & ~pv;
            pv = ped_req;
            sb.push_back((s <= 40) ? tl(s, 2'b01, er) : tl(s - 41, 2'b10, er));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = obs();
            n_chk++;
            if (o !== e) begin
                n_err++;
                $display("FAIL b2b s=%0d got %h exp %h", s, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_walk();
        logic [11:0] e, o;
        logic [1:0] er, pv;
        do_reset();
        er = 2'b00;
        pv = 2'b00;
        for (int s = 1; s <= 27; s++) begin
            ped_req = {s == 25, s == 2};
            if (s == 24) er = 2'b00;
            er |= ped_req & ~pv;
            pv = ped_req;
            sb.push_back(tl(s, 2'b01, er));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            o = obs();
            n_chk++;
            if (o !== e) begin
                n_err++;
                $display("FAIL midwalk s=%0d got %h exp %h", s, o, e);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        e = mk(3'd0, 2'b00, 2'b00, 2'b00);
        o = obs();
        n_chk++;
        if (o !== e) begin
            n_err++;
            $display("FAIL async_rst got %h exp %h", o, e);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

`ifdef PED_PREEMPT_EN
    task automatic test_preempt();
        logic [2:0] ep;
        bit ok;
        do_reset();
        preempt = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick = (i % 4 == 3);
            ped_req = (i == 1) ? 2'b01 : 2'b00;
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (phase !== 3'd0 || req_pending !== 2'b01) begin
            n_err++;
            $display("FAIL preempt_hold got %0d/%b exp 0/01", phase, req_pending);
        end
        preempt = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            tick = (i % 4 == 3);
            @(posedge clk);
            #1;
            if (phase == 3'd3) ok = 1'b1;
        end
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL preempt_walk_timeout got %0d exp 3", phase);
        end else begin
            for (int c = 0; c <= 40; c++) begin
                tick = (c % 4 == 3);
                if (c == 9) preempt = 1'b1;
                if (c < 11)      sb.push_back({9'd0, 3'd3});
                else if (c < 35) sb.push_back({9'd0, 3'd4});
                else if (c < 39) sb.push_back({9'd0, 3'd5});
                else             sb.push_back({9'd0, 3'd0});
                @(posedge clk);
                #1;
                ep = sb.pop_front()[2:0];
                n_chk++;
                if (phase !== ep) begin
                    n_err++;
                    $display("FAIL preempt_seq c=%0d got %0d exp %0d", c, phase, ep);
                end
            end
        end
        preempt = 1'b0;
        tick = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_single_walk();
        test_multi_walk();
        test_back_to_back();
        test_reset_mid_walk();
`ifdef PED_PREEMPT_EN
        test_preempt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ped_xing_ctrl.md
Name: ped_xing_ctrl

Overview:
Multi-crosswalk pedestrian/vehicle signal controller. It is the parametrised successor of the single-button walk controller. It adds:
- N latched crosswalk requests served together in one pedestrian phase.
- Programmable phase durations on an external tick time base.
- A minimum vehicle green time.
- A flashing don't-walk clearance phase.

It sits between synchronised, debounced button inputs and the lamp drivers.

Parameters:
- NUM_XWALK, 2: number of crosswalk channels (1..8).
- TIMER_W, 8: phase timer width in bits.
- GREEN_MIN, 20: minimum vehicle green, in ticks.
- YELLOW_TIME, 3: vehicle yellow, in ticks.
- ALLRED_TIME, 1: all-red interval, in ticks; used on both sides of the pedestrian phase.
- WALK_TIME, 10: steady walk, in ticks.
- CLEAR_TIME, 6: flashing don't-walk, in ticks.

Ports:
- clk, in, 1: clock; all logic is rising-edge.
- rst, in, 1: reset, asynchronous, active-high.
- tick, in, 1: single-cycle time-base enable; the timer advances only when tick=1.
- ped_req, in, NUM_XWALK: per-channel button level, already synchronous to clk.
- car_green, out, 1: vehicle green lamp.
- car_yellow, out, 1: vehicle yellow lamp.
- car_red, out, 1: vehicle red lamp.
- walk, out, NUM_XWALK: per-channel steady walk.
- dont_walk_flash, out, NUM_XWALK: per-channel flashing don't-walk, with the flash phase already applied.
- req_pending, out, NUM_XWALK: latched requests not yet served.
- phase, out, 3: current state encoding.

Behaviour:
- All outputs are registered.
- Reset values:
  - phase=GREEN, car_green=1, car_yellow=0, car_red=0.
  - walk=0, dont_walk_flash=0, req_pending=0.
  - Internal served mask = 0, flash phase = 0, ped_req edge history = 0.
  - timer = GREEN_MIN-1.
- States and encodings: GREEN=0, YELLOW=1, ALLRED1=2, WALK=3, CLEAR=4, ALLRED2=5. Codes 6 and 7 are illegal; if reached, the next clk edge goes to ALLRED2 with the ALLRED_TIME load.
- Timer:
  - On state entry, timer loads (duration-1).
  - On each tick with timer>0, timer decrements.
  - A tick with timer==0 takes the exit transition, except in GREEN (see below).
  - Each state therefore lasts exactly its duration in ticks.
- Transitions on a tick with timer==0:
  - GREEN -> YELLOW, only if req_pending != 0. Otherwise stay in GREEN with timer held at 0, so a later request leaves on the next tick after it latches.
  - YELLOW -> ALLRED1.
  - ALLRED1 -> WALK. On this transition, served <= req_pending and the req_pending bits just served are cleared.
  - WALK -> CLEAR.
  - CLEAR -> ALLRED2.
  - ALLRED2 -> GREEN. On this transition, served <= 0.
- Request latch:
  - A rising edge of ped_req[i] sets req_pending[i] on the following clk edge, in any state.
  - A held button latches once only.
  - If a set and the ALLRED1->WALK clear hit the same bit in the same cycle, the set wins: the bit stays pending and is also served.
  - Presses during WALK or CLEAR are latched for the next cycle and do not extend the current phase.
- Lamps:
  - car_green=1 only in GREEN; car_yellow=1 only in YELLOW; car_red=1 in all other states. Exactly one vehicle lamp is high at any time.
  - walk[i] = served[i] and phase==WALK.
  - dont_walk_flash[i] = served[i] and phase==CLEAR and flash phase==1.
  - The flash phase toggles on every tick in CLEAR and resets to 0 on CLEAR entry.
- Zero-duration parameters are illegal. An elaboration-time check must fail if any duration is 0 or does not fit in TIMER_W.
- Reset mid-operation: rst asserted in any state immediately forces the reset values above, including dropping walk; no pending requests are kept.

Optional Feature:
- Macro: PED_PREEMPT_EN.
- When defined, the block adds input port preempt (1 bit, level):
  - While preempt=1 in GREEN, the GREEN exit is blocked and requests are held latched.
  - preempt rising during WALK forces the transition to CLEAR on the next tick, regardless of timer.
  - YELLOW, ALLRED and CLEAR complete normally.
- When undefined, there is no preempt port and behaviour is exactly as above.

Test Plan:
Scenarios 1–5 use tick tied to 1 and default parameters.
1. Reset release, no presses for 100 cycles -> car_green stays 1, phase=0, walk=0 throughout.
2. ped_req[0] pulsed at cycle 5 after reset -> req_pending[0]=1 at cycle 6; then:
   - car_green for 20 cycles total, then car_yellow for 3, then all-red for 1.
   - walk=2'b01 for 10 cycles.
   - dont_walk_flash[0] toggling 0,1,0,1,0,1 over 6 cycles.
   - All-red for 1 cycle, then GREEN with req_pending=0.
3. ped_req[0] and ped_req[1] pressed at different GREEN cycles -> single WALK with walk=2'b11 and both pending bits cleared at WALK entry.
4. ped_req[1] pressed during WALK serving channel 0 only -> walk[1] stays 0; req_pending[1]=1 persists; the next cycle serves channel 1 after a full GREEN_MIN.
5. rst asserted during WALK cycle 4 -> walk=0 and car_green=1 with no clk edge needed; req_pending=0.
6. With PED_PREEMPT_EN and tick pulsed every 4th cycle: preempt raised mid-WALK -> CLEAR entered on the next tick; durations are counted in ticks, not cycles.
